// File: rtl/mdio_controller_if.sv
// Bundles the user-side request/response signals and the MDIO line signals of the controller.
interface mdio_controller_if;
  logic        mdio_start;
  logic [31:0] t_data;
  logic        mdio_in;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] rd_data;
  logic        data_rdy;
  logic        busy;

  modport master (
    input  mdio_start, t_data, mdio_in,
    output mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy
  );

  modport slave (
    output mdio_start, t_data, mdio_in,
    input  mdc, mdio_out, mdio_oe, rd_data, data_rdy, busy
  );
endinterface

// File: rtl/mdio_controller.sv
// MDIO station-management controller: divides clk down to MDC and shifts a 32-bit management
// frame (optionally preceded by a preamble) onto the line, capturing 16 data bits on reads.
module mdio_controller #(
  parameter int unsigned MDC_HALF = 2,
  parameter int unsigned PRE_LEN  = 0
) (
  input logic               clk,
  input logic               rst,
  mdio_controller_if.master bus
);

  localparam int unsigned     CntW    = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam int unsigned     PreW    = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MDC_HALF - 1);
  localparam logic [PreW-1:0] PreLast = PreW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

  typedef enum logic [2:0] {StIdle, StArm, StPre, StFrame, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mdc_q, mdc_d;
  logic [31:0]     shift_q, shift_d;
  logic            is_read_q, is_read_d;
  logic [4:0]      bit_q, bit_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [15:0]     cap_q, cap_d;
  logic            out_q, out_d;
  logic            oe_q, oe_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            wrap, rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mdc_q     <= 1'b0;
      shift_q   <= '0;
      is_read_q <= 1'b0;
      bit_q     <= '0;
      pre_q     <= '0;
      cap_q     <= '0;
      out_q     <= 1'b0;
      oe_q      <= 1'b0;
      rd_data_q <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mdc_q     <= mdc_d;
      shift_q   <= shift_d;
      is_read_q <= is_read_d;
      bit_q     <= bit_d;
      pre_q     <= pre_d;
      cap_q     <= cap_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
      rd_data_q <= rd_data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    // rise/fall mark the clk cycle in which the registered mdc changes level.
    wrap      = (cnt_q == CntLast);
    rise      = wrap & ~mdc_q;
    fall      = wrap & mdc_q;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    mdc_d     = wrap ? ~mdc_q : mdc_q;

    state_d   = state_q;
    shift_d   = shift_q;
    is_read_d = is_read_q;
    bit_d     = bit_q;
    pre_d     = pre_q;
    cap_d     = cap_q;
    out_d     = out_q;
    oe_d      = oe_q;
    rd_data_d = rd_data_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;

    unique case (state_q)
      StIdle: begin
        if (bus.mdio_start) begin
          shift_d   = bus.t_data;
          is_read_d = (bus.t_data[29:28] == 2'b10);
          busy_d    = 1'b1;
          state_d   = StArm;
        end
      end
      StArm: begin
        if (fall) begin
          oe_d  = 1'b1;
          bit_d = '0;
          if (PRE_LEN > 0) begin
            out_d   = 1'b1;
            pre_d   = '0;
            state_d = StPre;
          end else begin
            out_d   = shift_q[31];
            state_d = StFrame;
          end
        end
      end
      StPre: begin
        if (fall) begin
          if (pre_q == PreLast) begin
            out_d   = shift_q[31];
            state_d = StFrame;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      StFrame: begin
        if (rise && is_read_q && bit_q[4]) cap_d = {cap_q[14:0], bus.mdio_in};
        if (fall) begin
          if (bit_q == 5'd31) begin
            oe_d    = 1'b0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
            state_d = StDone;
            if (is_read_q) rd_data_d = cap_q;
          end else begin
            bit_d   = bit_q + 5'd1;
            shift_d = {shift_q[30:0], 1'b0};
            // Read frames hand the line to the PHY from bit 16 onwards.
            if (is_read_q && (bit_q >= 5'd15)) begin
              oe_d  = 1'b0;
              out_d = 1'b0;
            end else begin
              out_d = shift_q[30];
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.mdc      = mdc_q;
  assign bus.mdio_out = out_q;
  assign bus.mdio_oe  = oe_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.data_rdy = rdy_q;
  assign bus.busy     = busy_q;

endmodule
